unet_frame_seq: RTL and testbench
=================================

UNET_FRAME_SEQ -- requirements
Module: unet_frame_seq

Interface
REQ-001 Parameter DATA_W, default 12: pixel width on all stream channels.
REQ-002 Parameter CNT_W, default 20: width of beat-length and beat-count fields.
REQ-003 Parameter TMO_CYC, default 4096: idle-stall cycles before abort; only used with the timeout macro.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_start  in  1  one-cycle frame start request.
REQ-007 cfg_in_len  in  CNT_W  input beats per frame; sampled on an accepted start.
REQ-008 cfg_out_len  in  CNT_W  output beats per frame; sampled on an accepted start.
REQ-009 src_rsc_dat/vld/rdy  in/in/out  DATA_W/1/1  upstream pixel stream.
REQ-010 ip_in_rsc_dat/vld/rdy  out/out/in  DATA_W/1/1  to the UNET IP input channel.
REQ-011 ip_out_rsc_dat/vld/rdy  in/in/out  DATA_W/1/1  from the UNET IP output channel.
REQ-012 snk_rsc_dat/vld/rdy  out/out/in  DATA_W/1/1  downstream result stream.
REQ-013 busy, done, err_cfg, err_tmo  out  1 each  status: state not IDLE; completion pulse; rejected start pulse; sticky timeout flag.
REQ-014 in_cnt, out_cnt  out  CNT_W each  beats transferred in the current or last frame.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE after reset.
REQ-016 IDLE: all vld/rdy outputs 0; cfg_start with both lengths nonzero latches them, clears in_cnt, out_cnt, err_tmo, moves to RUN next cycle.
REQ-017 IDLE: cfg_start with either length 0 -> no state change, err_cfg=1 for exactly that cycle+1 (registered pulse).
REQ-018 cfg_start outside IDLE is ignored; no error.
REQ-019 Input gate: in_open = state RUN and in_cnt<in_len; ip_in_rsc_vld = src_rsc_vld & in_open; src_rsc_rdy = ip_in_rsc_rdy & in_open; dat passed through combinationally (zero latency).
REQ-020 Output gate: out_open = state RUN/DRAIN and out_cnt<out_len; snk_rsc_vld = ip_out_rsc_vld & out_open; ip_out_rsc_rdy = snk_rsc_rdy & out_open; dat passed through.
REQ-021 A beat counts when its vld&rdy are both 1 at the edge; in_cnt/out_cnt increment by 1, never exceed their lengths.
REQ-022 RUN -> DRAIN when in_cnt reaches in_len while out_cnt<out_len; RUN/DRAIN -> DONE when both counts reach their lengths (including same cycle as the last input beat).
REQ-023 DONE: done=1 and busy=1 for one cycle, then IDLE; counts hold until next accepted start.
REQ-024 Output beats arriving before input completes are accepted in RUN (IP may overlap).

Reset
REQ-025 rst mid-frame aborts immediately: state IDLE, counts 0, latched lengths 0, done/err_cfg/err_tmo 0, all gated vld/rdy 0 in the cycle after rst asserted.
REQ-026 rst does not reset the UNET IP; the system drives the IP's own rst from the same signal.

Configuration
REQ-027 Macro UNET_FRAME_SEQ_TIMEOUT_EN: when defined, a stall counter clears on any counted beat or state change, increments each RUN/DRAIN cycle otherwise; reaching TMO_CYC sets err_tmo and forces IDLE (no done pulse).
REQ-028 Without UNET_FRAME_SEQ_TIMEOUT_EN: no stall counter, err_tmo tied 0, frame waits indefinitely.

Structure
REQ-029 Package unet_seq_pkg holds the state enum, DATA_W/CNT_W defaults and TMO_CYC default.
REQ-030 One sub-module unet_seq_beat_cnt (saturating length-compare counter with clear), instantiated twice for input and output.

Verification
REQ-031 in_len=16, out_len=16, all vld/rdy 1 -> 16 beats each side; done pulses the cycle after the 16th beat; busy low one cycle later.
REQ-032 in_len=8, out_len=4, sink rdy 0 until input complete -> DRAIN entered after 8th input beat; src_rsc_rdy=0 thereafter; done after 4th output beat.
REQ-033 cfg_start with in_len=0 in IDLE -> err_cfg one-cycle pulse, busy stays 0; cfg_start during RUN -> ignored, lengths unchanged.
REQ-034 Extra upstream vld after in_cnt=in_len -> src_rsc_rdy=0, ip_in_rsc_vld=0, in_cnt stays at in_len.
REQ-035 rst asserted after 5 of 10 input beats -> next cycle busy=0, in_cnt=0, all gated handshakes 0; new start runs a full frame cleanly.
REQ-036 With UNET_FRAME_SEQ_TIMEOUT_EN, TMO_CYC=32, IP rdy held 0 -> err_tmo=1 at stall cycle 32, state IDLE, no done; without macro, same stimulus -> busy stays 1.

Source files
------------

// File: rtl/unet_seq_pkg.sv
// Shared types and default sizes for the UNET frame sequencer.
package unet_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    localparam int DATA_W_DEF  = 12;
    localparam int CNT_W_DEF   = 20;
    localparam int TMO_CYC_DEF = 4096;

endpackage

// File: rtl/unet_seq_beat_cnt.sv
// Beat counter that stops at a programmed length. It reports whether more
// beats are allowed and whether the count will equal the length after this
// edge, so the controller can change state on the final beat itself.
module unet_seq_beat_cnt
    import unet_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             beat_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             open_o,
    output logic             full_next_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise advance only while below the length.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_i && (cnt_q < len_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign open_o      = (cnt_q < len_i);
    assign full_next_o = (cnt_d == len_i);

endmodule

// File: rtl/unet_frame_seq.sv
// Frame sequencer around a UNET IP. It gates a fixed number of input beats
// into the IP and a fixed number of result beats out of it, then pulses done.
// Optional stall timeout: define UNET_FRAME_SEQ_TIMEOUT_EN to enable it.
module unet_frame_seq
    import unet_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_in_len,
    input  logic [CNT_W-1:0]  cfg_out_len,
    input  logic [DATA_W-1:0] src_rsc_dat,
    input  logic              src_rsc_vld,
    output logic              src_rsc_rdy,
    output logic [DATA_W-1:0] ip_in_rsc_dat,
    output logic              ip_in_rsc_vld,
    input  logic              ip_in_rsc_rdy,
    input  logic [DATA_W-1:0] ip_out_rsc_dat,
    input  logic              ip_out_rsc_vld,
    output logic              ip_out_rsc_rdy,
    output logic [DATA_W-1:0] snk_rsc_dat,
    output logic              snk_rsc_vld,
    input  logic              snk_rsc_rdy,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_tmo,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  out_cnt
);

    seq_state_e       state_q;
    logic [CNT_W-1:0] in_len_q;
    logic [CNT_W-1:0] out_len_q;
    logic             err_cfg_q;

    logic start_ok;
    logic start_bad;
    logic in_ctr_open;
    logic out_ctr_open;
    logic in_full_next;
    logic out_full_next;
    logic in_open;
    logic out_open;
    logic in_beat;
    logic out_beat;

    assign start_ok  = (state_q == IDLE) && cfg_start &&
                       (cfg_in_len != '0) && (cfg_out_len != '0);
    assign start_bad = (state_q == IDLE) && cfg_start &&
                       ((cfg_in_len == '0) || (cfg_out_len == '0));

    assign in_open  = (state_q == RUN) && in_ctr_open;
    assign out_open = ((state_q == RUN) || (state_q == DRAIN)) && out_ctr_open;

    assign ip_in_rsc_dat  = src_rsc_dat;
    assign ip_in_rsc_vld  = src_rsc_vld & in_open;
    assign src_rsc_rdy    = ip_in_rsc_rdy & in_open;
    assign snk_rsc_dat    = ip_out_rsc_dat;
    assign snk_rsc_vld    = ip_out_rsc_vld & out_open;
    assign ip_out_rsc_rdy = snk_rsc_rdy & out_open;

    assign in_beat  = src_rsc_vld & ip_in_rsc_rdy & in_open;
    assign out_beat = ip_out_rsc_vld & snk_rsc_rdy & out_open;

    unet_seq_beat_cnt #(.CNT_W(CNT_W)) u_in_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .beat_i      (in_beat),
        .len_i       (in_len_q),
        .cnt_o       (in_cnt),
        .open_o      (in_ctr_open),
        .full_next_o (in_full_next)
    );

    unet_seq_beat_cnt #(.CNT_W(CNT_W)) u_out_cnt (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .beat_i      (out_beat),
        .len_i       (out_len_q),
        .cnt_o       (out_cnt),
        .open_o      (out_ctr_open),
        .full_next_o (out_full_next)
    );

`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
    localparam int STALL_W = $clog2(TMO_CYC + 1);
    logic [STALL_W-1:0] stall_q;
    logic               err_tmo_q;
`endif

    // Frame control: start/abort, run-to-drain-to-done sequencing, error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_len_q  <= '0;
            out_len_q <= '0;
            err_cfg_q <= 1'b0;
`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
            stall_q   <= '0;
            err_tmo_q <= 1'b0;
`endif
        end else begin
            err_cfg_q <= start_bad;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        in_len_q  <= cfg_in_len;
                        out_len_q <= cfg_out_len;
                        state_q   <= RUN;
`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
                        err_tmo_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (in_full_next && out_full_next) begin
                        state_q <= DONE;
                    end else if (in_full_next) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_full_next) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
            // Every state change inside a frame coincides with a beat, so a
            // beat alone is enough to restart the stall window.
            if ((state_q == RUN) || (state_q == DRAIN)) begin
                if (in_beat || out_beat) begin
                    stall_q <= '0;
                end else if (stall_q == STALL_W'(TMO_CYC - 1)) begin
                    stall_q   <= '0;
                    err_tmo_q <= 1'b1;
                    state_q   <= IDLE;
                end else begin
                    stall_q <= stall_q + 1'b1;
                end
            end else begin
                stall_q <= '0;
            end
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err_cfg = err_cfg_q;
`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
    assign err_tmo = err_tmo_q;
`else
    assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_unet_frame_seq.sv
// Directed bench for unet_frame_seq. Built with TMO_CYC=32; the stall test
// expects an abort only when UNET_FRAME_SEQ_TIMEOUT_EN is defined.
module tb_unet_frame_seq;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [CNT_W-1:0]  cfg_in_len;
    logic [CNT_W-1:0]  cfg_out_len;
    logic [DATA_W-1:0] src_rsc_dat;
    logic              src_rsc_vld;
    logic              src_rsc_rdy;
    logic [DATA_W-1:0] ip_in_rsc_dat;
    logic              ip_in_rsc_vld;
    logic              ip_in_rsc_rdy;
    logic [DATA_W-1:0] ip_out_rsc_dat;
    logic              ip_out_rsc_vld;
    logic              ip_out_rsc_rdy;
    logic [DATA_W-1:0] snk_rsc_dat;
    logic              snk_rsc_vld;
    logic              snk_rsc_rdy;
    logic              busy;
    logic              done;
    logic              err_cfg;
    logic              err_tmo;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    unet_frame_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TMO_CYC(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_in_len     (cfg_in_len),
        .cfg_out_len    (cfg_out_len),
        .src_rsc_dat    (src_rsc_dat),
        .src_rsc_vld    (src_rsc_vld),
        .src_rsc_rdy    (src_rsc_rdy),
        .ip_in_rsc_dat  (ip_in_rsc_dat),
        .ip_in_rsc_vld  (ip_in_rsc_vld),
        .ip_in_rsc_rdy  (ip_in_rsc_rdy),
        .ip_out_rsc_dat (ip_out_rsc_dat),
        .ip_out_rsc_vld (ip_out_rsc_vld),
        .ip_out_rsc_rdy (ip_out_rsc_rdy),
        .snk_rsc_dat    (snk_rsc_dat),
        .snk_rsc_vld    (snk_rsc_vld),
        .snk_rsc_rdy    (snk_rsc_rdy),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_tmo        (err_tmo),
        .in_cnt         (in_cnt),
        .out_cnt        (out_cnt)
    );

    // Advance one clock; outputs are then read 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_streams(input logic sv, input logic ir, input logic ov, input logic sr);
        src_rsc_vld    = sv;
        ip_in_rsc_rdy  = ir;
        ip_out_rsc_vld = ov;
        snk_rsc_rdy    = sr;
    endtask

    // One-cycle start request with the given lengths.
    task automatic start_frame(input int il, input int ol);
        cfg_in_len  = CNT_W'(il);
        cfg_out_len = CNT_W'(ol);
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_in_len = '0;
        cfg_out_len = '0;
        src_rsc_dat = '0;
        ip_out_rsc_dat = '0;
        set_streams(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_cfg !== 1'b0 || err_tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status busy/done/err_cfg/err_tmo=%b%b%b%b required 0000", busy, done, err_cfg, err_tmo);
        end
        checks++;
        if (in_cnt !== '0 || out_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts in=%0d out=%0d required 0/0", in_cnt, out_cnt);
        end
        checks++;
        if ({ip_in_rsc_vld, src_rsc_rdy, snk_rsc_vld, ip_out_rsc_rdy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_gates got %b required 0000", {ip_in_rsc_vld, src_rsc_rdy, snk_rsc_vld, ip_out_rsc_rdy});
        end
    endtask

    task automatic test_full_stream();
        set_streams(1'b1, 1'b1, 1'b1, 1'b1);
        start_frame(16, 16);
        checks++;
        if (busy !== 1'b1 || ip_in_rsc_vld !== 1'b1 || src_rsc_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_run_entry busy/vld/rdy=%b%b%b required 111", busy, ip_in_rsc_vld, src_rsc_rdy);
        end
        for (int i = 0; i < 16; i++) begin
            src_rsc_dat    = DATA_W'(12'h100 + i);
            ip_out_rsc_dat = DATA_W'(12'hA00 + i);
            #1;
            checks++;
            if (ip_in_rsc_dat !== DATA_W'(12'h100 + i) || snk_rsc_dat !== DATA_W'(12'hA00 + i)) begin
                errors++;
                $display("[TB] FAIL full_passthru beat %0d in_dat=%h snk_dat=%h required %h/%h", i, ip_in_rsc_dat, snk_rsc_dat, 12'h100 + i, 12'hA00 + i);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL full_early_done beat %0d done=%b required 0", i, done);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || in_cnt !== 16 || out_cnt !== 16) begin
            errors++;
            $display("[TB] FAIL full_done done=%b busy=%b in=%0d out=%0d required 1/1/16/16", done, busy, in_cnt, out_cnt);
        end
        checks++;
        if (src_rsc_rdy !== 1'b0 || snk_rsc_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_done_gates src_rdy=%b snk_vld=%b required 0/0", src_rsc_rdy, snk_rsc_vld);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_cnt !== 16 || out_cnt !== 16) begin
            errors++;
            $display("[TB] FAIL full_idle busy=%b done=%b in=%0d out=%0d required 0/0/16/16", busy, done, in_cnt, out_cnt);
        end
    endtask

    task automatic test_drain();
        set_streams(1'b1, 1'b1, 1'b1, 1'b0);
        start_frame(8, 4);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || in_cnt !== 8 || out_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL drain_entry busy=%b done=%b in=%0d out=%0d required 1/0/8/0", busy, done, in_cnt, out_cnt);
        end
        checks++;
        if (src_rsc_rdy !== 1'b0 || ip_in_rsc_vld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_in_closed src_rdy=%b ip_vld=%b required 0/0", src_rsc_rdy, ip_in_rsc_vld);
        end
        snk_rsc_rdy = 1'b1;
        #1;
        checks++;
        if (ip_out_rsc_rdy !== 1'b1 || snk_rsc_vld !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drain_out_open ip_out_rdy=%b snk_vld=%b required 1/1", ip_out_rsc_rdy, snk_rsc_vld);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (done !== 1'b0 || out_cnt !== 3) begin
            errors++;
            $display("[TB] FAIL drain_mid done=%b out=%0d required 0/3", done, out_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b1 || out_cnt !== 4 || in_cnt !== 8) begin
            errors++;
            $display("[TB] FAIL drain_done done=%b in=%0d out=%0d required 1/8/4", done, in_cnt, out_cnt);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_idle busy=%b required 0", busy);
        end
    endtask

    task automatic test_cfg_errors();
        set_streams(1'b0, 1'b0, 1'b0, 1'b0);
        start_frame(0, 5);
        checks++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_zero_pulse err_cfg=%b busy=%b required 1/0", err_cfg, busy);
        end
        tick();
        checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cfg_zero_clear err_cfg=%b busy=%b required 0/0", err_cfg, busy);
        end
        start_frame(4, 4);
        checks++;
        if (busy !== 1'b1 || err_cfg !== 1'b0 || in_cnt !== 0 || out_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL cfg_start_ok busy=%b err_cfg=%b in=%0d out=%0d required 1/0/0/0", busy, err_cfg, in_cnt, out_cnt);
        end
        start_frame(2, 2);
        checks++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_run_ignored err_cfg=%b busy=%b required 0/1", err_cfg, busy);
        end
        set_streams(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (done !== 1'b0 || in_cnt !== 3) begin
            errors++;
            $display("[TB] FAIL cfg_len_kept_mid done=%b in=%0d required 0/3", done, in_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b1 || in_cnt !== 4 || out_cnt !== 4) begin
            errors++;
            $display("[TB] FAIL cfg_len_kept_done done=%b in=%0d out=%0d required 1/4/4", done, in_cnt, out_cnt);
        end
        tick();
    endtask

    task automatic test_overrun();
        set_streams(1'b1, 1'b1, 1'b0, 1'b0);
        start_frame(3, 6);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (src_rsc_rdy !== 1'b0 || ip_in_rsc_vld !== 1'b0 || in_cnt !== 3) begin
            errors++;
            $display("[TB] FAIL overrun_hold src_rdy=%b ip_vld=%b in=%0d required 0/0/3", src_rsc_rdy, ip_in_rsc_vld, in_cnt);
        end
        set_streams(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done !== 1'b1 || in_cnt !== 3 || out_cnt !== 6) begin
            errors++;
            $display("[TB] FAIL overrun_done done=%b in=%0d out=%0d required 1/3/6", done, in_cnt, out_cnt);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        set_streams(1'b1, 1'b1, 1'b0, 1'b0);
        start_frame(10, 10);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (in_cnt !== 5 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pre in=%0d busy=%b required 5/1", in_cnt, busy);
        end
        ip_out_rsc_vld = 1'b1;
        snk_rsc_rdy    = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || in_cnt !== 0 || out_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL midrst_state busy=%b done=%b in=%0d out=%0d required 0/0/0/0", busy, done, in_cnt, out_cnt);
        end
        checks++;
        if ({ip_in_rsc_vld, src_rsc_rdy, snk_rsc_vld, ip_out_rsc_rdy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midrst_gates got %b required 0000", {ip_in_rsc_vld, src_rsc_rdy, snk_rsc_vld, ip_out_rsc_rdy});
        end
        rst = 1'b0;
        start_frame(10, 10);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (done !== 1'b1 || in_cnt !== 10 || out_cnt !== 10) begin
            errors++;
            $display("[TB] FAIL midrst_refrm done=%b in=%0d out=%0d required 1/10/10", done, in_cnt, out_cnt);
        end
        tick();
    endtask

    task automatic test_stall();
        logic saw_done;
        saw_done = 1'b0;
        set_streams(1'b1, 1'b0, 1'b1, 1'b0);
        start_frame(4, 4);
`ifdef UNET_FRAME_SEQ_TIMEOUT_EN
        for (int i = 0; i < 31; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (busy !== 1'b1 || err_tmo !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_pre busy=%b err_tmo=%b required 1/0", busy, err_tmo);
        end
        tick();
        if (done === 1'b1) saw_done = 1'b1;
        checks++;
        if (busy !== 1'b0 || err_tmo !== 1'b1 || saw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_abort busy=%b err_tmo=%b saw_done=%b required 0/1/0", busy, err_tmo, saw_done);
        end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (busy !== 1'b1 || err_tmo !== 1'b0 || saw_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_wait busy=%b err_tmo=%b saw_done=%b required 1/0/0", busy, err_tmo, saw_done);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_full_stream();
        test_drain();
        test_cfg_errors();
        test_overrun();
        test_mid_reset();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
